// File: rtl/kernel_ctrl_pkg.sv
// kernel_ctrl_pkg
//   Shared types and defaults for the kernel launch controller.
//   - state_t      : controller state encoding
//   - DEF_*        : default parameter values for the controller and its slots
//   - CNT_SAT_ALL  : all-ones pattern; the low CNT_WIDTH bits form the
//                    saturation value of the run-latency counter
package kernel_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_NUM_ARGS     = 2;
  localparam int unsigned DEF_ARG_WIDTH    = 32;
  localparam int unsigned DEF_NUM_RES      = 1;
  localparam int unsigned DEF_RES_WIDTH    = 32;
  localparam int unsigned DEF_HAS_CONTINUE = 1;
  localparam int unsigned DEF_CNT_WIDTH    = 16;
  localparam int unsigned CNT_MAX_WIDTH    = 64;

  localparam logic [CNT_MAX_WIDTH-1:0] CNT_SAT_ALL = '1;

endpackage

// File: rtl/kernel_result_slot.sv
// kernel_result_slot
//   One result capture channel: a data register plus a one-shot capture flag.
//   Ready is offered only while the controller is running and the slot has not
//   yet captured in the current launch.
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     i_launch   : new launch accepted; clears the capture flag (data is kept)
//     i_run      : controller is in RUN
//     i_data     : kernel result data
//     i_valid    : kernel result valid
//     o_ready    : result ready back to the kernel
//     o_data     : captured result held for the host
//     o_done     : slot captured already, or is capturing this cycle
module kernel_result_slot
  import kernel_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_RES_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_launch,
  input  logic             i_run,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_done
);

  logic             r_cap;
  logic [WIDTH-1:0] r_data;
  logic             w_hs;

  assign o_ready = i_run & ~r_cap;
  assign w_hs    = o_ready & i_valid;
  assign o_done  = r_cap | w_hs;
  assign o_data  = r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap  <= 1'b0;
      r_data <= '0;
    end else if (i_launch) begin
      // Captured data stays visible to the host until a new capture.
      r_cap <= 1'b0;
    end else if (w_hs) begin
      r_cap  <= 1'b1;
      r_data <= i_data;
    end
  end

endmodule

// File: rtl/kernel_launch_ctrl.sv
// kernel_launch_ctrl
//   Bridges the ap_* block-level protocol to a valid/ready kernel. Arguments
//   are latched on launch and each offered once; results and the end token are
//   captured independently and held for the host. Run latency is counted.
//   Ports:
//     clk, rst                   : clock, synchronous active-high reset
//     ap_start/continue          : host launch request / result acknowledge
//     ap_ready/idle/done         : host status
//     args_in/out, args_valid/ready : argument channels
//     start_valid/ready          : control token channel
//     res_in, res_in_valid/ready : kernel result channels
//     end_valid/ready            : kernel end token
//     res_out                    : captured results
//     run_cycles                 : saturating RUN-cycle count
//
//   state | meaning
//   IDLE  | waiting for ap_start; ap_ready/ap_idle high
//   RUN   | offering args/start token, capturing results and end token
//   DONE  | results held; waits for ap_continue (or one cycle if none)
module kernel_launch_ctrl
  import kernel_ctrl_pkg::*;
#(
  parameter int unsigned NUM_ARGS     = DEF_NUM_ARGS,
  parameter int unsigned ARG_WIDTH    = DEF_ARG_WIDTH,
  parameter int unsigned NUM_RES      = DEF_NUM_RES,
  parameter int unsigned RES_WIDTH    = DEF_RES_WIDTH,
  parameter int unsigned HAS_CONTINUE = DEF_HAS_CONTINUE,
  parameter int unsigned CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ap_start,
  input  logic                          ap_continue,
  output logic                          ap_ready,
  output logic                          ap_idle,
  output logic                          ap_done,
  input  logic [NUM_ARGS*ARG_WIDTH-1:0] args_in,
  output logic [NUM_ARGS*ARG_WIDTH-1:0] args_out,
  output logic [NUM_ARGS-1:0]           args_valid,
  input  logic [NUM_ARGS-1:0]           args_ready,
  output logic                          start_valid,
  input  logic                          start_ready,
  input  logic [NUM_RES*RES_WIDTH-1:0]  res_in,
  input  logic [NUM_RES-1:0]            res_in_valid,
  output logic [NUM_RES-1:0]            res_in_ready,
  input  logic                          end_valid,
  output logic                          end_ready,
  output logic [NUM_RES*RES_WIDTH-1:0]  res_out,
  output logic [CNT_WIDTH-1:0]          run_cycles
);

  localparam logic [CNT_WIDTH-1:0] CNT_SAT = CNT_SAT_ALL[CNT_WIDTH-1:0];

  state_t                        r_state;
  logic [NUM_ARGS*ARG_WIDTH-1:0] r_args;
  logic [NUM_ARGS-1:0]           r_sent;
  logic                          r_start_sent;
  logic                          r_end_cap;
  logic [CNT_WIDTH-1:0]          r_run_cycles;

  logic                          w_run;
  logic                          w_launch;
  logic [NUM_RES-1:0]            w_res_done;
  logic                          w_end_done;
  logic                          w_all_done;

  assign w_run    = (r_state == ST_RUN);
  assign w_launch = (r_state == ST_IDLE) & ap_start;

  assign ap_ready    = (r_state == ST_IDLE);
  assign ap_idle     = (r_state == ST_IDLE);
  assign ap_done     = (r_state == ST_DONE);
  assign args_out    = r_args;
  assign args_valid  = {NUM_ARGS{w_run}} & ~r_sent;
  assign start_valid = w_run & ~r_start_sent;
  assign end_ready   = w_run & ~r_end_cap;
  assign run_cycles  = r_run_cycles;

  // A channel handshaking in the final cycle counts as complete.
  assign w_end_done = r_end_cap | (end_ready & end_valid);
  assign w_all_done = (&w_res_done) & w_end_done;

  for (genvar j = 0; j < NUM_RES; j++) begin : g_res
    kernel_result_slot #(
      .WIDTH (RES_WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .i_launch (w_launch),
      .i_run    (w_run),
      .i_data   (res_in[j*RES_WIDTH +: RES_WIDTH]),
      .i_valid  (res_in_valid[j]),
      .o_ready  (res_in_ready[j]),
      .o_data   (res_out[j*RES_WIDTH +: RES_WIDTH]),
      .o_done   (w_res_done[j])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_args       <= '0;
      r_sent       <= '0;
      r_start_sent <= 1'b0;
      r_end_cap    <= 1'b0;
      r_run_cycles <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ap_start) begin
            r_args       <= args_in;
            r_sent       <= '0;
            r_start_sent <= 1'b0;
            r_end_cap    <= 1'b0;
            r_run_cycles <= '0;
            r_state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_sent       <= r_sent | (args_valid & args_ready);
          r_start_sent <= r_start_sent | (start_valid & start_ready);
          r_end_cap    <= w_end_done;
          if (r_run_cycles != CNT_SAT) begin
            r_run_cycles <= r_run_cycles + 1'b1;
          end
          // Unconsumed arguments are abandoned once the kernel has ended.
          if (w_all_done) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if ((HAS_CONTINUE == 0) || ap_continue) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_launch_ctrl.sv
module tb_kernel_launch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // DUT A: 2 x 32-bit args, 1 result, continue handshake, 16-bit counter
  logic        rst_a, start_a, cont_a, ready_a, idle_a, done_a;
  logic [63:0] args_in_a, args_out_a;
  logic [1:0]  args_valid_a, args_ready_a;
  logic        start_valid_a, start_ready_a;
  logic [31:0] res_in_a, res_out_a;
  logic [0:0]  res_in_valid_a, res_in_ready_a;
  logic        end_valid_a, end_ready_a;
  logic [15:0] run_cycles_a;

  // DUT B: 2 x 8-bit args, 2 x 8-bit results, no continue, 4-bit counter
  logic        rst_b, start_b, cont_b, ready_b, idle_b, done_b;
  logic [15:0] args_in_b, args_out_b;
  logic [1:0]  args_valid_b, args_ready_b;
  logic        start_valid_b, start_ready_b;
  logic [15:0] res_in_b, res_out_b;
  logic [1:0]  res_in_valid_b, res_in_ready_b;
  logic        end_valid_b, end_ready_b;
  logic [3:0]  run_cycles_b;

  kernel_launch_ctrl #(
    .NUM_ARGS(2), .ARG_WIDTH(32), .NUM_RES(1), .RES_WIDTH(32),
    .HAS_CONTINUE(1), .CNT_WIDTH(16)
  ) dut_a (
    .clk(clk), .rst(rst_a), .ap_start(start_a), .ap_continue(cont_a),
    .ap_ready(ready_a), .ap_idle(idle_a), .ap_done(done_a),
    .args_in(args_in_a), .args_out(args_out_a),
    .args_valid(args_valid_a), .args_ready(args_ready_a),
    .start_valid(start_valid_a), .start_ready(start_ready_a),
    .res_in(res_in_a), .res_in_valid(res_in_valid_a), .res_in_ready(res_in_ready_a),
    .end_valid(end_valid_a), .end_ready(end_ready_a),
    .res_out(res_out_a), .run_cycles(run_cycles_a)
  );

  kernel_launch_ctrl #(
    .NUM_ARGS(2), .ARG_WIDTH(8), .NUM_RES(2), .RES_WIDTH(8),
    .HAS_CONTINUE(0), .CNT_WIDTH(4)
  ) dut_b (
    .clk(clk), .rst(rst_b), .ap_start(start_b), .ap_continue(cont_b),
    .ap_ready(ready_b), .ap_idle(idle_b), .ap_done(done_b),
    .args_in(args_in_b), .args_out(args_out_b),
    .args_valid(args_valid_b), .args_ready(args_ready_b),
    .start_valid(start_valid_b), .start_ready(start_ready_b),
    .res_in(res_in_b), .res_in_valid(res_in_valid_b), .res_in_ready(res_in_ready_b),
    .end_valid(end_valid_b), .end_ready(end_ready_b),
    .res_out(res_out_b), .run_cycles(run_cycles_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b1; start_a = 1'b0; cont_a = 1'b0; args_in_a = '0; args_ready_a = '0;
    start_ready_a = 1'b0; res_in_a = '0; res_in_valid_a = '0; end_valid_a = 1'b0;
    rst_b = 1'b1; start_b = 1'b0; cont_b = 1'b0; args_in_b = '0; args_ready_b = '0;
    start_ready_b = 1'b0; res_in_b = '0; res_in_valid_b = '0; end_valid_b = 1'b0;
    tick();
    tick();
    rst_a = 1'b0;
    rst_b = 1'b0;

    // reset state
    check("a_rst_ready",   64'(ready_a), 64'h1);
    check("a_rst_idle",    64'(idle_a), 64'h1);
    check("a_rst_done",    64'(done_a), 64'h0);
    check("a_rst_argv",    64'(args_valid_a), 64'h0);
    check("a_rst_startv",  64'(start_valid_a), 64'h0);
    check("a_rst_resrdy",  64'(res_in_ready_a), 64'h0);
    check("a_rst_endrdy",  64'(end_ready_a), 64'h0);
    check("a_rst_resout",  64'(res_out_a), 64'h0);
    check("a_rst_args",    64'(args_out_a), 64'h0);
    check("a_rst_cycles",  64'(run_cycles_a), 64'h0);
    check("b_rst_ready",   64'(ready_b), 64'h1);
    check("b_rst_resout",  64'(res_out_b), 64'h0);

    // ---- A: basic flow, results in the first RUN cycle
    start_a = 1'b1; args_in_a = {32'h22, 32'h11};
    args_ready_a = 2'b11; start_ready_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("a_run_argv",    64'(args_valid_a), 64'h3);
    check("a_run_args",    64'(args_out_a), 64'h00000022_00000011);
    check("a_run_startv",  64'(start_valid_a), 64'h1);
    check("a_run_resrdy",  64'(res_in_ready_a), 64'h1);
    check("a_run_endrdy",  64'(end_ready_a), 64'h1);
    check("a_run_done",    64'(done_a), 64'h0);
    check("a_run_ready",   64'(ready_a), 64'h0);
    res_in_a = 32'h33; res_in_valid_a = 1'b1; end_valid_a = 1'b1;
    tick();
    res_in_valid_a = 1'b0; end_valid_a = 1'b0;
    check("a_done",        64'(done_a), 64'h1);
    check("a_done_argv",   64'(args_valid_a), 64'h0);
    check("a_done_startv", 64'(start_valid_a), 64'h0);
    check("a_done_resout", 64'(res_out_a), 64'h33);
    check("a_done_cycles", 64'(run_cycles_a), 64'h1);
    check("a_done_resrdy", 64'(res_in_ready_a), 64'h0);
    check("a_done_endrdy", 64'(end_ready_a), 64'h0);

    // ---- A: DONE held without ap_continue; ap_start ignored meanwhile
    for (int k = 0; k < 10; k++) begin
      start_a = (k >= 3 && k < 6);
      tick();
      check("a_hold_done",  64'(done_a), 64'h1);
      check("a_hold_ready", 64'(ready_a), 64'h0);
    end
    start_a = 1'b0;
    check("a_hold_cycles", 64'(run_cycles_a), 64'h1);
    cont_a = 1'b1;
    tick();
    cont_a = 1'b0;
    check("a_cont_idle",   64'(idle_a), 64'h1);
    check("a_cont_done",   64'(done_a), 64'h0);
    check("a_cont_resout", 64'(res_out_a), 64'h33);

    // ---- A: relaunch with argument backpressure
    args_ready_a = 2'b00;
    start_a = 1'b1; args_in_a = {32'hBB, 32'hAA};
    tick();
    start_a = 1'b0;
    args_in_a = {32'hDEAD, 32'hBEEF};
    check("a_bp_launched", 64'(idle_a), 64'h0);
    for (int k = 0; k < 4; k++) begin
      check("a_bp_argv", 64'(args_valid_a), 64'h3);
      check("a_bp_args", 64'(args_out_a), 64'h000000BB_000000AA);
      tick();
    end
    args_ready_a = 2'b11;
    check("a_bp_argv_last", 64'(args_valid_a), 64'h3);
    tick();
    check("a_bp_argv_off1", 64'(args_valid_a), 64'h0);
    check("a_bp_startv",    64'(start_valid_a), 64'h0);
    tick();
    check("a_bp_argv_off2", 64'(args_valid_a), 64'h0);
    res_in_a = 32'h44; res_in_valid_a = 1'b1; end_valid_a = 1'b1;
    tick();
    res_in_valid_a = 1'b0; end_valid_a = 1'b0;
    check("a_bp_done",   64'(done_a), 64'h1);
    check("a_bp_resout", 64'(res_out_a), 64'h44);
    check("a_bp_cycles", 64'(run_cycles_a), 64'h7);
    cont_a = 1'b1;
    tick();
    cont_a = 1'b0;
    check("a_bp_idle", 64'(idle_a), 64'h1);

    // ---- B: staggered results (res0 @2, end @5, res1 @7)
    args_ready_b = 2'b11; start_ready_b = 1'b1;
    start_b = 1'b1; args_in_b = {8'h22, 8'h11};
    tick();
    start_b = 1'b0;
    for (int k = 0; k < 8; k++) begin
      res_in_valid_b[0] = (k >= 2);
      res_in_valid_b[1] = (k == 7);
      end_valid_b       = (k >= 5);
      res_in_b          = {8'hC3, (k == 2) ? 8'h5A : 8'hEE};
      check("b_stg_rdy0", 64'(res_in_ready_b[0]), 64'(k <= 2));
      check("b_stg_rdy1", 64'(res_in_ready_b[1]), 64'h1);
      check("b_stg_endr", 64'(end_ready_b), 64'(k <= 5));
      check("b_stg_done", 64'(done_b), 64'h0);
      tick();
    end
    res_in_valid_b = 2'b00; end_valid_b = 1'b0;
    check("b_stg_done8",  64'(done_b), 64'h1);
    check("b_stg_resout", 64'(res_out_b), 64'hC35A);
    check("b_stg_cycles", 64'(run_cycles_b), 64'h8);
    check("b_stg_argv",   64'(args_valid_b), 64'h0);

    // ---- B: one-cycle DONE, ap_start held, relaunch right after
    start_b = 1'b1; args_in_b = {8'h44, 8'h33};
    tick();
    check("b_nc_done",   64'(done_b), 64'h0);
    check("b_nc_idle",   64'(idle_b), 64'h1);
    check("b_nc_resout", 64'(res_out_b), 64'hC35A);
    tick();
    start_b = 1'b0;
    check("b_re_idle",   64'(idle_b), 64'h0);
    check("b_re_args",   64'(args_out_b), 64'h4433);
    check("b_re_argv",   64'(args_valid_b), 64'h3);
    check("b_re_cycles", 64'(run_cycles_b), 64'h0);
    check("b_re_resout", 64'(res_out_b), 64'hC35A);

    // ---- B: reset mid-RUN after res0 captured
    res_in_b = {8'h99, 8'h77}; res_in_valid_b = 2'b01;
    tick();
    res_in_valid_b = 2'b00;
    check("b_part_resout", 64'(res_out_b), 64'hC377);
    check("b_part_rdy",    64'(res_in_ready_b), 64'h2);
    check("b_part_cycles", 64'(run_cycles_b), 64'h1);
    rst_b = 1'b1; res_in_valid_b = 2'b11; end_valid_b = 1'b1;
    tick();
    rst_b = 1'b0; res_in_valid_b = 2'b00; end_valid_b = 1'b0;
    check("b_mrst_idle",   64'(idle_b), 64'h1);
    check("b_mrst_done",   64'(done_b), 64'h0);
    check("b_mrst_resout", 64'(res_out_b), 64'h0);
    check("b_mrst_argv",   64'(args_valid_b), 64'h0);
    check("b_mrst_startv", 64'(start_valid_b), 64'h0);
    check("b_mrst_rdy",    64'(res_in_ready_b), 64'h0);
    check("b_mrst_endr",   64'(end_ready_b), 64'h0);
    check("b_mrst_cycles", 64'(run_cycles_b), 64'h0);
    check("b_mrst_args",   64'(args_out_b), 64'h0);

    // ---- B: counter saturation with a 20-cycle run
    start_b = 1'b1; args_in_b = {8'h66, 8'h55};
    tick();
    start_b = 1'b0;
    for (int k = 0; k < 14; k++) tick();
    check("b_sat_14", 64'(run_cycles_b), 64'hE);
    for (int k = 0; k < 6; k++) tick();
    check("b_sat_20", 64'(run_cycles_b), 64'hF);
    res_in_b = {8'hAB, 8'hCD}; res_in_valid_b = 2'b11; end_valid_b = 1'b1;
    tick();
    res_in_valid_b = 2'b00; end_valid_b = 1'b0;
    check("b_sat_done",   64'(done_b), 64'h1);
    check("b_sat_cycles", 64'(run_cycles_b), 64'hF);
    check("b_sat_resout", 64'(res_out_b), 64'hABCD);
    tick();
    check("b_sat_idle", 64'(idle_b), 64'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
